// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider: per channel a one-cycle tick and a 50% duty divided clock.
// Optional CLKDIV_SYNC_EN adds sync_in, which realigns every channel to phase zero on one edge.
module clock_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 24,
    parameter int DEFAULT_DIV = 4194304,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              basys_clock,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync_in,
`endif
    output logic [NUM_CH-1:0] cfg_pend,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] out_clock
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

    logic sync_hit;
`ifdef CLKDIV_SYNC_EN
    assign sync_hit = sync_in;
`else
    assign sync_hit = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] shadow;
        logic             pend_q;
        logic             tick_q;
        logic             out_q;
        logic             cfg_hit;

        // Out-of-range channel numbers never match, so such writes are dropped.
        assign cfg_hit = cfg_we && (cfg_ch == CH_W'(i));

        always_ff @(posedge basys_clock or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                div_q  <= RST_DIV;
                shadow <= RST_DIV;
                pend_q <= 1'b0;
                tick_q <= 1'b0;
                out_q  <= 1'b0;
            end else begin
                if (sync_hit) begin
                    cnt    <= '0;
                    tick_q <= 1'b0;
                    out_q  <= 1'b0;
                    if (pend_q) begin
                        div_q  <= shadow;
                        pend_q <= 1'b0;
                    end
                end else if (!en[i]) begin
                    tick_q <= 1'b0;
                    // Restart the period when a new divisor lands so cnt stays below div_q.
                    if (pend_q) begin
                        div_q  <= shadow;
                        pend_q <= 1'b0;
                        cnt    <= '0;
                    end
                end else if (div_q == '0) begin
                    cnt    <= '0;
                    tick_q <= 1'b0;
                    if (pend_q) begin
                        div_q  <= shadow;
                        pend_q <= 1'b0;
                    end
                end else if (cnt == div_q - DIV_W'(1)) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    out_q  <= ~out_q;
                    if (pend_q) begin
                        div_q  <= shadow;
                        pend_q <= 1'b0;
                    end
                end else begin
                    cnt    <= cnt + DIV_W'(1);
                    tick_q <= 1'b0;
                end

                // A write on an apply edge lets the old shadow land; the new value stays pending.
                if (cfg_hit) begin
                    shadow <= cfg_div;
                    pend_q <= 1'b1;
                end
            end
        end

        assign cfg_pend[i]  = pend_q;
        assign tick[i]      = tick_q;
        assign out_clock[i] = out_q;
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed and randomized bench for clock_div_multi against a cycle-level period model.
module tb_clock_div_multi;
  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 6;
  localparam int CH_W        = 2;
  localparam int VW          = 3 * NUM_CH;

  logic              basys_clock = 1'b0;
  logic              rst_n       = 1'b0;
  logic [NUM_CH-1:0] en          = '0;
  logic              cfg_we      = 1'b0;
  logic [CH_W-1:0]   cfg_ch      = '0;
  logic [DIV_W-1:0]  cfg_div     = '0;
  logic              sync_drv    = 1'b0;
  logic [NUM_CH-1:0] cfg_pend;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] out_clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [VW-1:0] exp_q[$];

  // Model: active period length, position inside the period, queued next period.
  int m_per[NUM_CH];
  int m_pos[NUM_CH];
  int m_nxt[NUM_CH];
  bit m_pend[NUM_CH];
  bit m_tick[NUM_CH];
  bit m_out[NUM_CH];

  clock_div_multi #(
    .NUM_CH(NUM_CH),
    .DIV_W(DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .basys_clock(basys_clock),
    .rst_n(rst_n),
    .en(en),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
`ifdef CLKDIV_SYNC_EN
    .sync_in(sync_drv),
`endif
    .cfg_pend(cfg_pend),
    .tick(tick),
    .out_clock(out_clock)
  );

  // clock / reset
  always #5 basys_clock = ~basys_clock;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_per[c] = DEFAULT_DIV; m_nxt[c] = DEFAULT_DIV; m_pos[c] = 0;
      m_pend[c] = 0; m_tick[c] = 0; m_out[c] = 0;
    end
  endtask

  task automatic apply_pending(int c);
    if (m_pend[c]) begin
      m_per[c] = m_nxt[c];
      m_pend[c] = 0;
    end
  endtask

  // One rising edge of the model, using the inputs currently driven.
  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      bit wr;
      wr = cfg_we && (int'(cfg_ch) == c);
      if (sync_drv) begin
        m_pos[c] = 0; m_tick[c] = 0; m_out[c] = 0;
        apply_pending(c);
      end else if (!en[c]) begin
        m_tick[c] = 0;
        if (m_pend[c]) m_pos[c] = 0;
        apply_pending(c);
      end else if (m_per[c] == 0) begin
        m_pos[c] = 0; m_tick[c] = 0;
        apply_pending(c);
      end else begin
        m_pos[c] = (m_pos[c] + 1) % m_per[c];
        m_tick[c] = (m_pos[c] == 0);
        if (m_tick[c]) begin
          m_out[c] = !m_out[c];
          apply_pending(c);
        end
      end
      if (wr) begin
        m_nxt[c] = int'(cfg_div);
        m_pend[c] = 1;
      end
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      v[c] = m_tick[c];
      v[NUM_CH + c] = m_out[c];
      v[2*NUM_CH + c] = m_pend[c];
    end
    return v;
  endfunction

  // scoreboard
  task automatic check(string tag, logic [NUM_CH-1:0] obs, logic [NUM_CH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    logic [VW-1:0] e;
    e = exp_q.pop_front();
    check({tag, ".tick"}, tick, e[NUM_CH-1:0]);
    check({tag, ".out_clock"}, out_clock, e[2*NUM_CH-1:NUM_CH]);
    check({tag, ".cfg_pend"}, cfg_pend, e[3*NUM_CH-1:2*NUM_CH]);
  endtask

  // drivers
  task automatic cycle(string tag);
    model_edge();
    exp_q.push_back(model_vec());
    @(posedge basys_clock);
    #1;
    check_all(tag);
  endtask

  task automatic run(string tag, int n);
    repeat (n) cycle(tag);
  endtask

  task automatic write_cfg(string tag, int ch, int div);
    cfg_we = 1'b1;
    cfg_ch = CH_W'(ch);
    cfg_div = DIV_W'(div);
    cycle(tag);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    check({tag, ".tick"}, tick, '0);
    check({tag, ".out_clock"}, out_clock, '0);
    check({tag, ".cfg_pend"}, cfg_pend, '0);
    @(posedge basys_clock);
    #1;
    exp_q.push_back(model_vec());
    check_all({tag, "_hold"});
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset("reset");

    // 1) ch0 divisor 5 loaded while stalled, then running.
    en = 3'b000;
    write_cfg("t1_wr", 0, 5);
    run("t1_apply", 1);
    en = 3'b001;
    run("t1_run", 25);

    // 2) ch1 div 3, then 7 written mid-count.
    en = 3'b001;
    write_cfg("t2_wr3", 1, 3);
    run("t2_apply", 1);
    en = 3'b011;
    run("t2_run3", 7);
    write_cfg("t2_wr7", 1, 7);
    run("t2_run7", 20);

    // 3) ch2 div 1, then div 0.
    en = 3'b011;
    write_cfg("t3_wr1", 2, 1);
    run("t3_apply", 1);
    en = 3'b111;
    run("t3_div1", 6);
    write_cfg("t3_wr0", 2, 0);
    run("t3_div0", 8);

    // 4) ch0 disabled for 10 cycles at position 2 of 5.
    for (int k = 0; k < 20 && m_pos[0] != 2; k++) cycle("t4_align");
    en[0] = 1'b0;
    run("t4_off", 10);
    en[0] = 1'b1;
    run("t4_resume", 12);

    // 5) write to a nonexistent channel, then reset mid-count.
    write_cfg("t5_badch", 3, 2);
    run("t5_after", 4);
    write_cfg("t5_pendwr", 1, 4);
    do_reset("t5_reset");
    en = 3'b111;
    run("t5_default", 14);

`ifdef CLKDIV_SYNC_EN
    // 6) two channels out of phase, realigned by one sync pulse.
    en = 3'b000;
    write_cfg("t6_wr0", 0, 4);
    write_cfg("t6_wr1", 1, 6);
    run("t6_apply", 1);
    en = 3'b001;
    run("t6_skew", 3);
    en = 3'b011;
    run("t6_run", 5);
    sync_drv = 1'b1;
    cycle("t6_sync");
    sync_drv = 1'b0;
    run("t6_after", 13);
`endif

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) en = NUM_CH'($urandom_range(0, 7));
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_ch = CH_W'($urandom_range(0, 3));
      cfg_div = DIV_W'($urandom_range(0, 7));
`ifdef CLKDIV_SYNC_EN
      sync_drv = ($urandom_range(0, 31) == 0);
`endif
      cycle("rand");
    end
    cfg_we = 1'b0;
    sync_drv = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
